// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - playback modes, FSM encoding and sizing/fill helpers for seq_pattern_gen
package seq_gen_pkg;

    localparam logic [1:0] MODE_LOOP     = 2'b00;
    localparam logic [1:0] MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

    // Direction lives in the FSM state; loop and one-shot only ever use ST_UP.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10
    } seq_state_t;

    function automatic int unsigned addr_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] reset_entry(input int unsigned idx, input int unsigned width);
        return (width >= 32) ? idx : (idx & ((32'd1 << width) - 32'd1));
    endfunction

endpackage

// File: rtl/seq_table.sv
// rtl/seq_table.sv - DEPTH x WIDTH pattern register file with reset fill and write-to-read bypass
module seq_table
    import seq_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = addr_width(DEPTH)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;

    assign wr_ok = wr_en && (32'(wr_addr) < DEPTH);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= WIDTH'(reset_entry(i, WIDTH));
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A write landing on the entry being loaded this cycle must be seen immediately.
    always_comb begin
        rd_data = '0;
        if (wr_ok && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end else if (32'(rd_addr) < DEPTH) begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - programmable table-driven sequence generator (loop / one-shot / ping-pong)
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = addr_width(DEPTH),
    parameter int unsigned LW    = addr_width(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Wr_En,
    input  logic [AW-1:0]    Wr_Addr,
    input  logic [WIDTH-1:0] Wr_Data,
    input  logic             Cfg_We,
    input  logic [LW-1:0]    Cfg_Len,
    input  logic [1:0]       Cfg_Mode,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Step,
    output logic [WIDTH-1:0] State,
    output logic [AW-1:0]    Index,
    output logic             Running,
    output logic             Wrap,
    output logic             Done
);

    seq_state_t       fsm_q, fsm_d;
    logic [AW-1:0]    index_d;
    logic             load_d;
    logic             wrap_d;
    logic             done_d;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    cfg_len_norm;
    logic [1:0]       mode_q;
    logic [AW-1:0]    last_idx;
    logic             at_last;
    logic             at_first;
    logic             len_one;
    logic [WIDTH-1:0] table_rd;

    seq_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .Clk     (Clk),
        .Rst     (Rst),
        .wr_en   (Wr_En),
        .wr_addr (Wr_Addr),
        .wr_data (Wr_Data),
        .rd_addr (index_d),
        .rd_data (table_rd)
    );

    // len_q is always in 1..DEPTH, so len_q-1 fits in AW bits.
    assign last_idx = AW'(len_q - LW'(1));
    assign at_last  = (Index == last_idx);
    assign at_first = (Index == '0);
    assign len_one  = (len_q == LW'(1));

    always_comb begin
        cfg_len_norm = Cfg_Len;
        if (Cfg_Len == '0) begin
            cfg_len_norm = LW'(1);
        end else if (32'(Cfg_Len) > DEPTH) begin
            cfg_len_norm = LW'(DEPTH);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            len_q  <= LW'(DEPTH);
            mode_q <= MODE_LOOP;
        end else if (Cfg_We && (fsm_q == ST_IDLE)) begin
            len_q  <= cfg_len_norm;
            mode_q <= Cfg_Mode;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            fsm_q <= ST_IDLE;
            Index <= '0;
            State <= '0;
            Wrap  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            Index <= index_d;
            Wrap  <= wrap_d;
            Done  <= done_d;
            if (load_d) begin
                State <= table_rd;
            end
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        index_d = Index;
        load_d  = 1'b0;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        if (Start) begin
            fsm_d   = ST_UP;
            index_d = '0;
            load_d  = 1'b1;
        end else if (Stop) begin
            fsm_d = ST_IDLE;
        end else if (Step && (fsm_q != ST_IDLE)) begin
            case (mode_q)
                MODE_ONESHOT: begin
                    if (at_last) begin
                        fsm_d  = ST_IDLE;
                        done_d = 1'b1;
                    end else begin
                        index_d = Index + AW'(1);
                        load_d  = 1'b1;
                    end
                end
                MODE_PINGPONG: begin
                    load_d = 1'b1;
                    if (len_one) begin
                        index_d = '0;
                        wrap_d  = 1'b1;
                    end else if (fsm_q == ST_UP) begin
                        if (at_last) begin
                            fsm_d   = ST_DOWN;
                            index_d = last_idx - AW'(1);
                            wrap_d  = 1'b1;
                        end else begin
                            index_d = Index + AW'(1);
                        end
                    end else begin
                        if (at_first) begin
                            fsm_d   = ST_UP;
                            index_d = AW'(1);
                            wrap_d  = 1'b1;
                        end else begin
                            index_d = Index - AW'(1);
                        end
                    end
                end
                default: begin
                    load_d = 1'b1;
                    if (at_last) begin
                        index_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        index_d = Index + AW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        Running = (fsm_q != ST_IDLE);
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - directed self-checking bench for seq_pattern_gen
module tb_seq_pattern_gen;

    logic       Clk;
    logic       Rst;
    logic       Wr_En;
    logic [2:0] Wr_Addr;
    logic [2:0] Wr_Data;
    logic       Cfg_We;
    logic [3:0] Cfg_Len;
    logic [1:0] Cfg_Mode;
    logic       Start;
    logic       Stop;
    logic       Step;
    logic [2:0] State;
    logic [2:0] Index;
    logic       Running;
    logic       Wrap;
    logic       Done;

    int n_checks;
    int n_fail;

    seq_pattern_gen dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Wr_En    (Wr_En),
        .Wr_Addr  (Wr_Addr),
        .Wr_Data  (Wr_Data),
        .Cfg_We   (Cfg_We),
        .Cfg_Len  (Cfg_Len),
        .Cfg_Mode (Cfg_Mode),
        .Start    (Start),
        .Stop     (Stop),
        .Step     (Step),
        .State    (State),
        .Index    (Index),
        .Running  (Running),
        .Wrap     (Wrap),
        .Done     (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
    endtask

    task automatic do_cfg(input logic [3:0] len, input logic [1:0] mode);
        Cfg_We = 1'b1; Cfg_Len = len; Cfg_Mode = mode;
        tick();
        Cfg_We = 1'b0;
    endtask

    task automatic do_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({State, Index, Running, Wrap, Done} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got State=%0d Index=%0d Running=%0b Wrap=%0b Done=%0b, expected all zero",
                     State, Index, Running, Wrap, Done);
        end
    endtask

    task automatic test_loop();
        int exp_st;
        do_reset();
        do_start();
        n_checks++;
        if (State !== 3'd0 || Running !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_start: got State=%0d Running=%0b, expected 0/1", State, Running);
        end
        Step = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_st = k % 8;
            n_checks++;
            if (State !== 3'(exp_st) || Index !== 3'(exp_st)) begin
                n_fail++;
                $display("FAIL loop_state step %0d: got State=%0d Index=%0d, expected %0d", k, State, Index, exp_st);
            end
            n_checks++;
            if (Wrap !== (k == 8)) begin
                n_fail++;
                $display("FAIL loop_wrap step %0d: got %0b, expected %0b", k, Wrap, (k == 8));
            end
        end
        Step = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [2:0] pat [7] = '{3'd7, 3'd3, 3'd1, 3'd0, 3'd2, 3'd4, 3'd6};
        int         idx;
        do_reset();
        for (int a = 0; a < 7; a++) begin
            Wr_En = 1'b1; Wr_Addr = 3'(a); Wr_Data = pat[a];
            tick();
        end
        Wr_En = 1'b0;
        do_cfg(4'd7, 2'b01);
        do_start();
        n_checks++;
        if (State !== 3'd7) begin
            n_fail++;
            $display("FAIL oneshot_start: got State=%0d, expected 7", State);
        end
        Step = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            idx = (k < 6) ? k : 6;
            n_checks++;
            if (State !== pat[idx]) begin
                n_fail++;
                $display("FAIL oneshot_state step %0d: got %0d, expected %0d", k, State, pat[idx]);
            end
            n_checks++;
            if (Done !== (k == 7) || Running !== (k < 7)) begin
                n_fail++;
                $display("FAIL oneshot_flags step %0d: got Done=%0b Running=%0b, expected Done=%0b Running=%0b",
                         k, Done, Running, (k == 7), (k < 7));
            end
        end
        Step = 1'b0;
    endtask

    task automatic test_pingpong();
        int exp_seq [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
        do_reset();
        do_cfg(4'd4, 2'b10);
        do_start();
        Step = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (State !== 3'(exp_seq[k])) begin
                n_fail++;
                $display("FAIL pingpong_state step %0d: got %0d, expected %0d", k + 1, State, exp_seq[k]);
            end
            n_checks++;
            if (Wrap !== (k == 3 || k == 6)) begin
                n_fail++;
                $display("FAIL pingpong_wrap step %0d: got %0b, expected %0b", k + 1, Wrap, (k == 3 || k == 6));
            end
        end
        Step = 1'b0;
    endtask

    task automatic test_cfg_while_running();
        int exp_seq [3] = '{1, 2, 0};
        do_reset();
        do_start();
        do_cfg(4'd3, 2'b00);
        Step = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_checks++;
            if (State !== 3'(k % 8)) begin
                n_fail++;
                $display("FAIL cfg_ignored step %0d: got %0d, expected %0d", k, State, k % 8);
            end
        end
        Step = 1'b0;
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        Step = 1'b1;
        tick();
        Step = 1'b0;
        n_checks++;
        if (Running !== 1'b0 || State !== 3'd1 || Index !== 3'd1) begin
            n_fail++;
            $display("FAIL stop_hold: got Running=%0b State=%0d Index=%0d, expected 0/1/1", Running, State, Index);
        end
        do_cfg(4'd3, 2'b00);
        do_start();
        n_checks++;
        if (State !== 3'd0) begin
            n_fail++;
            $display("FAIL len3_start: got %0d, expected 0", State);
        end
        Step = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (State !== 3'(exp_seq[k]) || Wrap !== (k == 2)) begin
                n_fail++;
                $display("FAIL len3_seq step %0d: got State=%0d Wrap=%0b, expected %0d/%0b",
                         k + 1, State, Wrap, exp_seq[k], (k == 2));
            end
        end
        Step = 1'b0;
    endtask

    task automatic test_len_bounds();
        do_reset();
        do_cfg(4'd0, 2'b00);
        do_start();
        Step = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_checks++;
            if (State !== 3'd0 || Index !== 3'd0 || Wrap !== 1'b1) begin
                n_fail++;
                $display("FAIL len0_loop step %0d: got State=%0d Index=%0d Wrap=%0b, expected 0/0/1",
                         k, State, Index, Wrap);
            end
        end
        Step = 1'b0;
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        do_cfg(4'd0, 2'b01);
        do_start();
        Step = 1'b1;
        tick();
        Step = 1'b0;
        n_checks++;
        if (Done !== 1'b1 || Running !== 1'b0 || State !== 3'd0) begin
            n_fail++;
            $display("FAIL len0_oneshot: got Done=%0b Running=%0b State=%0d, expected 1/0/0", Done, Running, State);
        end
        do_cfg(4'd15, 2'b00);
        do_start();
        Step = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if (State !== 3'(k % 8) || Wrap !== (k == 8)) begin
                n_fail++;
                $display("FAIL len_clamp step %0d: got State=%0d Wrap=%0b, expected %0d/%0b",
                         k, State, Wrap, k % 8, (k == 8));
            end
        end
        Step = 1'b0;
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        do_cfg(4'd2, 2'b11);
        do_start();
        Step = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_checks++;
            if (State !== 3'(k % 2) || Wrap !== (k == 2)) begin
                n_fail++;
                $display("FAIL mode11_loop step %0d: got State=%0d Wrap=%0b, expected %0d/%0b",
                         k, State, Wrap, k % 2, (k == 2));
            end
        end
        Step = 1'b0;
    endtask

    task automatic test_bypass_and_reset();
        do_reset();
        do_start();
        Step = 1'b1;
        tick();
        Wr_En = 1'b1; Wr_Addr = 3'd2; Wr_Data = 3'd5;
        tick();
        n_checks++;
        if (State !== 3'd5 || Index !== 3'd2) begin
            n_fail++;
            $display("FAIL bypass: got State=%0d Index=%0d, expected 5/2", State, Index);
        end
        Wr_Addr = 3'd5; Wr_Data = 3'd7;
        tick();
        Wr_En = 1'b0;
        n_checks++;
        if (State !== 3'd3) begin
            n_fail++;
            $display("FAIL other_addr_write: got State=%0d, expected 3", State);
        end
        tick();
        tick();
        n_checks++;
        if (State !== 3'd7 || Index !== 3'd5) begin
            n_fail++;
            $display("FAIL revisit_written: got State=%0d Index=%0d, expected 7/5", State, Index);
        end
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        Step = 1'b0;
        n_checks++;
        if (State !== 3'd0 || Index !== 3'd0 || Running !== 1'b0 || Wrap !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: got State=%0d Index=%0d Running=%0b Wrap=%0b Done=%0b, expected zeros",
                     State, Index, Running, Wrap, Done);
        end
        do_start();
        Step = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if (State !== 3'(k)) begin
                n_fail++;
                $display("FAIL table_refill step %0d: got %0d, expected %0d", k, State, k);
            end
        end
        Step = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Rst = 1'b1; Wr_En = 1'b0; Wr_Addr = '0; Wr_Data = '0;
        Cfg_We = 1'b0; Cfg_Len = '0; Cfg_Mode = '0;
        Start = 1'b0; Stop = 1'b0; Step = 1'b0;
        test_reset();
        test_loop();
        test_oneshot();
        test_pingpong();
        test_cfg_while_running();
        test_len_bounds();
        test_bypass_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
